// File: rtl/aud_pkg.sv
// Shared audio types and widths for the recorder and player stages.
// Pure definitions, no logic.
package aud_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 20;
  localparam int BITCNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_SHIFT,
    ST_WRITE,
    ST_PAUSED
  } rec_state_t;

endpackage

// File: rtl/aud_shift_in.sv
// Serial-to-parallel MSB-first shifter. It raises done in the same cycle as the 16th enabled bit,
// so the word is complete on the following cycle. There is no backpressure: it shifts whenever enabled.
module aud_shift_in
  import aud_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                en,
  input  logic                bit_in,
  output logic [SAMPLE_W-1:0] word,
  output logic                done
);

  logic [BITCNT_W-1:0] cnt;

  assign done = en && (cnt == {BITCNT_W{1'b1}});

  // The counter wraps naturally after 16 bits. Clear only rewinds the count, so the
  // finished word stays readable while the FSM writes it out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      word <= {word[SAMPLE_W-2:0], bit_in};
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aud_recorder.sv
// I2S left-channel recorder. A sample is written at edge k+17 after the LRC falling edge; address and length advance one edge later.
// There is no backpressure: the SRAM write strobe is fire-and-forget, and control pulses act on the next edge.
module aud_recorder
  import aud_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_MAX = 20'hFFFFF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_lrc,
  input  logic                i_data,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  output logic [ADDR_W-1:0]   o_address,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_wr,
  output logic [ADDR_W-1:0]   o_len,
  output logic                o_busy,
  output logic                o_full
);

  rec_state_t          state, state_nxt;
  logic                lrc_q;
  logic                lrc_fall;
  logic                pause_pend, pause_pend_nxt;
  logic                fresh_start;
  logic                do_write;
  logic                shift_en;
  logic                shift_done;
  logic [SAMPLE_W-1:0] word;

  assign lrc_fall = lrc_q && !i_lrc;
  assign shift_en = (state == ST_SHIFT);
  assign o_busy   = (state != ST_IDLE);

  aud_shift_in u_shift (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clear  (!shift_en),
    .en     (shift_en),
    .bit_in (i_data),
    .word   (word),
    .done   (shift_done)
  );

  always_comb begin
    state_nxt      = state;
    pause_pend_nxt = pause_pend;
    fresh_start    = 1'b0;
    do_write       = 1'b0;
    case (state)
      ST_IDLE: begin
        pause_pend_nxt = 1'b0;
        if (i_start && !i_stop) begin
          state_nxt   = ST_WAIT_FRAME;
          fresh_start = 1'b1;
        end
      end
      ST_WAIT_FRAME: begin
        pause_pend_nxt = 1'b0;
        if (i_stop)        state_nxt = ST_IDLE;
        else if (i_pause)  state_nxt = ST_PAUSED;
        else if (lrc_fall) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (i_stop) begin
          state_nxt      = ST_IDLE;
          pause_pend_nxt = 1'b0;
        end else begin
          if (i_pause)    pause_pend_nxt = 1'b1;
          if (shift_done) state_nxt      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        pause_pend_nxt = 1'b0;
        if (i_stop) begin
          state_nxt = ST_IDLE;
        end else begin
          do_write = 1'b1;
          // A pause requested during capture takes effect only after the sample lands.
          if (o_address == ADDR_MAX)      state_nxt = ST_IDLE;
          else if (pause_pend || i_pause) state_nxt = ST_PAUSED;
          else                            state_nxt = ST_WAIT_FRAME;
        end
      end
      ST_PAUSED: begin
        pause_pend_nxt = 1'b0;
        if (i_stop)       state_nxt = ST_IDLE;
        else if (i_start) state_nxt = ST_WAIT_FRAME;
      end
      default: begin
        state_nxt      = ST_IDLE;
        pause_pend_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      lrc_q      <= 1'b1;
      pause_pend <= 1'b0;
      o_address  <= '0;
      o_data     <= '0;
      o_wr       <= 1'b0;
      o_len      <= '0;
      o_full     <= 1'b0;
    end else begin
      state      <= state_nxt;
      lrc_q      <= i_lrc;
      pause_pend <= pause_pend_nxt;
      if (fresh_start) begin
        o_address <= '0;
        o_len     <= '0;
        o_full    <= 1'b0;
        o_wr      <= 1'b0;
      end else if (do_write) begin
        o_wr   <= 1'b1;
        o_data <= word;
        if (o_address == ADDR_MAX) o_full <= 1'b1;
      end else if (o_wr) begin
        // Bookkeeping trails the strobe so o_address still names the written word while o_wr is high.
        o_wr  <= 1'b0;
        o_len <= o_len + 1'b1;
        if (!o_full) o_address <= o_address + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aud_recorder.sv
// Randomized I2S bench: two recorders (full-size and ADDR_MAX=3) share stimulus,
// with a frame-level reference model feeding per-DUT write scoreboards.
module tb_aud_recorder;
  import aud_pkg::*;

  localparam int M_IDLE = 0, M_REC = 1, M_PAUSED = 2;

  typedef struct packed {
    logic [31:0] c;
    logic [19:0] a;
    logic [15:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lrc = 1'b1;
  logic sdata = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic stop = 1'b0;

  logic [19:0] addr0, len0, addr1, len1;
  logic [15:0] data0, data1;
  logic        wr0, busy0, full0, wr1, busy1, full1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  int          m_mode[2];
  logic [19:0] m_addr[2];
  logic [19:0] m_len[2];
  logic        m_full[2];
  logic [19:0] maxv[2];

  aud_recorder dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdata),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_address(addr0), .o_data(data0), .o_wr(wr0), .o_len(len0),
    .o_busy(busy0), .o_full(full0)
  );

  aud_recorder #(.ADDR_MAX(20'd3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(sdata),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_address(addr1), .o_data(data1), .o_wr(wr1), .o_len(len1),
    .o_busy(busy1), .o_full(full1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (frame granularity) ----------------
  task automatic m_reset(input int d);
    m_mode[d] = M_IDLE;
    m_addr[d] = '0;
    m_len[d]  = '0;
    m_full[d] = 1'b0;
  endtask

  task automatic m_event(input int d, input logic [3:0] ev);
    if (ev[3]) m_reset(d);
    else if (ev[2]) m_mode[d] = M_IDLE;
    else if (ev[1] && m_mode[d] == M_REC) m_mode[d] = M_PAUSED;
    else if (ev[0] && m_mode[d] != M_REC) begin
      if (m_mode[d] == M_IDLE) begin
        m_addr[d] = '0;
        m_len[d]  = '0;
        m_full[d] = 1'b0;
      end
      m_mode[d] = M_REC;
    end
  endtask

  task automatic m_frame(input int d, input logic [15:0] left, input int evp,
                         input logic [3:0] ev, input int base);
    bit   cap;
    bit   inwin;
    exp_t e;
    cap = (m_mode[d] == M_REC);
    if (evp == 0 && ev != 4'b0) begin
      m_event(d, ev);
      cap = cap && (m_mode[d] == M_REC) && !ev[3];
    end
    inwin = (evp >= 1 && evp <= 17);
    if (cap && inwin && (ev[3] || ev[2])) begin
      if (ev[3]) m_reset(d);
      else m_mode[d] = M_IDLE;
    end else if (cap) begin
      e.c = 32'(base + 17);
      e.a = m_addr[d];
      e.d = left;
      if (d == 0) sb0.push_back(e);
      else sb1.push_back(e);
      m_len[d] = m_len[d] + 20'd1;
      if (m_addr[d] == maxv[d]) begin
        m_full[d] = 1'b1;
        m_mode[d] = M_IDLE;
      end else begin
        m_addr[d] = m_addr[d] + 20'd1;
        m_mode[d] = (inwin && ev[1]) ? M_PAUSED : M_REC;
      end
      if (evp >= 18) m_event(d, ev);
    end else if (evp >= 1) begin
      m_event(d, ev);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int d, input logic wr, input logic [19:0] a, input logic [15:0] dt);
    exp_t e;
    int   sz;
    if (wr) begin
      sz = (d == 0) ? sb0.size() : sb1.size();
      if (sz == 0) begin
        check($sformatf("dut%0d unexpected_wr", d), 32'(wr), 32'd0);
      end else begin
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        check($sformatf("dut%0d wr_addr", d), 32'(a), 32'(e.a));
        check($sformatf("dut%0d wr_data", d), 32'(dt), 32'(e.d));
        check($sformatf("dut%0d wr_cycle", d), 32'(cyc), e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, wr0, addr0, data0);
    mon(1, wr1, addr1, data1);
  end

  task automatic check_reset_outs();
    check("rst addr0", 32'(addr0), 0);  check("rst data0", 32'(data0), 0);
    check("rst wr0", 32'(wr0), 0);      check("rst len0", 32'(len0), 0);
    check("rst full0", 32'(full0), 0);  check("rst busy0", 32'(busy0), 0);
    check("rst addr1", 32'(addr1), 0);  check("rst data1", 32'(data1), 0);
    check("rst wr1", 32'(wr1), 0);      check("rst len1", 32'(len1), 0);
    check("rst full1", 32'(full1), 0);  check("rst busy1", 32'(busy1), 0);
  endtask

  task automatic frame_checks();
    check("addr0", 32'(addr0), 32'(m_addr[0]));
    check("len0", 32'(len0), 32'(m_len[0]));
    check("full0", 32'(full0), 32'(m_full[0]));
    check("busy0", 32'(busy0), 32'(m_mode[0] != M_IDLE));
    check("pending0", 32'(sb0.size()), 0);
    check("addr1", 32'(addr1), 32'(m_addr[1]));
    check("len1", 32'(len1), 32'(m_len[1]));
    check("full1", 32'(full1), 32'(m_full[1]));
    check("busy1", 32'(busy1), 32'(m_mode[1] != M_IDLE));
    check("pending1", 32'(sb1.size()), 0);
  endtask

  // One 64-BCLK I2S frame; ev = {rst, stop, pause, start} applied at edge k+evp.
  task automatic frame(input logic [15:0] left, input logic [15:0] right,
                       input int evp, input logic [3:0] ev);
    int base;
    @(negedge clk);
    base = cyc + 1;
    m_frame(0, left, evp, ev, base);
    m_frame(1, left, evp, ev, base);
    for (int p = 0; p < 64; p++) begin
      if (p > 0) @(negedge clk);
      lrc = (p >= 32);
      if (p >= 1 && p <= 16) sdata = left[16-p];
      else if (p >= 33 && p <= 48) sdata = right[48-p];
      else sdata = 1'($urandom_range(0, 1));
      start = (p == evp) && ev[0];
      pause = (p == evp) && ev[1];
      stop  = (p == evp) && ev[2];
      rst_n = !((p == evp) && ev[3]);
      if (!rst_n) begin
        #1;
        check_reset_outs();
      end
      if (p == 63) frame_checks();
    end
  endtask

  initial begin
    logic [3:0] ev;
    int         evp;
    int         r;
    maxv[0] = 20'hFFFFF;
    maxv[1] = 20'd3;
    m_reset(0);
    m_reset(1);

    repeat (3) @(negedge clk);
    #1;
    check_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // No start yet: nothing must be captured.
    frame(16'h1234, 16'hFFFF, 40, 4'b0000);
    // Single frame.
    frame(16'h0000, 16'hFFFF, 40, 4'b0001);
    frame(16'hA5C3, 16'hFFFF, 0, 4'b0000);
    // Three frames, right channel full of ones.
    frame(16'h0001, 16'hFFFF, 0, 4'b0000);
    frame(16'h8000, 16'hFFFF, 0, 4'b0000);
    frame(16'h7FFF, 16'hFFFF, 0, 4'b0000);
    // Stop mid-sample after a fresh start and one good frame.
    frame(16'h0000, 16'hFFFF, 40, 4'b0101);
    frame(16'h1111, 16'hFFFF, 40, 4'b0001);
    frame(16'h2222, 16'hFFFF, 8, 4'b0100);
    // Pause at the 5th bit, three idle frames, then resume.
    frame(16'h0000, 16'hFFFF, 40, 4'b0001);
    frame(16'h3C3C, 16'hFFFF, 5, 4'b0010);
    frame(16'h4444, 16'hFFFF, 0, 4'b0000);
    frame(16'h5555, 16'hFFFF, 0, 4'b0000);
    frame(16'h6666, 16'hFFFF, 40, 4'b0001);
    frame(16'h7777, 16'hFFFF, 0, 4'b0000);
    // Run the small instance past its last address.
    for (int i = 0; i < 6; i++) frame(16'(i * 16'h1357), 16'hFFFF, 0, 4'b0000);
    frame(16'h0BAD, 16'hFFFF, 40, 4'b0001);
    frame(16'h0C0D, 16'hFFFF, 0, 4'b0000);
    // All three pulses together in SHIFT, then a reset pulse mid-frame.
    frame(16'h9999, 16'hFFFF, 8, 4'b0111);
    frame(16'h0000, 16'hFFFF, 40, 4'b0001);
    frame(16'hAAAA, 16'hFFFF, 8, 4'b1000);
    frame(16'hBBBB, 16'hFFFF, 0, 4'b0000);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      if (r < 6) ev = 4'b0000;
      else if (r < 12) ev = 4'b0001;
      else if (r < 14) ev = 4'b0010;
      else if (r < 16) ev = 4'b0100;
      else if (r < 19) ev = {1'b0, 3'($urandom_range(0, 7))};
      else ev = 4'b1000;
      evp = $urandom_range(0, 60);
      if (evp == 18 || evp == 19) evp = 20;
      frame(16'($urandom), 16'($urandom), evp, ev);
    end

    repeat (4) @(negedge clk);
    check("final pending0", 32'(sb0.size()), 0);
    check("final pending1", 32'(sb1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aud_recorder.md
AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 Parameter ADDR_MAX, default 20'hFFFFF, last SRAM word address usable for samples.
REQ-002 i_clk  in  1  WM8731 AUD_BCLK; the block's single clock; all logic on rising edge.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_lrc  in  1  AUD_ADCLRCK (low = left channel, I2S mode).
REQ-005 i_data  in  1  AUD_ADCDAT serial sample bit, MSB first.
REQ-006 i_start  in  1  one-cycle pulse: begin/resume recording.
REQ-007 i_pause  in  1  one-cycle pulse: pause recording.
REQ-008 i_stop  in  1  one-cycle pulse: stop recording.
REQ-009 o_address  out  20  SRAM word address of current/next sample.
REQ-010 o_data  out  16  captured left-channel sample, two's complement.
REQ-011 o_wr  out  1  one-cycle write strobe; o_address/o_data valid while high.
REQ-012 o_len  out  20  number of samples written since last fresh start.
REQ-013 o_busy  out  1  high in any state except IDLE.
REQ-014 o_full  out  1  high once sample at ADDR_MAX written; cleared by fresh start.

Function
REQ-015 FSM states: IDLE, WAIT_FRAME, SHIFT, WRITE, PAUSED.
REQ-016 LRC falling edge detected at the rising edge where registered i_lrc is 1 and i_lrc is 0 (edge k).
REQ-017 IDLE + i_start: clear o_address, o_len, o_full -> WAIT_FRAME.
REQ-018 WAIT_FRAME: on LRC falling edge at edge k -> SHIFT; bits captured at edges k+1..k+16 (one-BCLK I2S delay), MSB first.
REQ-019 SHIFT: after 16th bit -> WRITE; 4-bit counter counts captured bits.
REQ-020 WRITE: o_wr high exactly one cycle (edge k+17), o_data = captured word, o_address = target address; next edge o_address += 1, o_len += 1.
REQ-021 After WRITE: if written address == ADDR_MAX, set o_full and go IDLE (o_address held at ADDR_MAX); else WAIT_FRAME.
REQ-022 Right-channel bits and any bits outside the 16-bit window ignored.
REQ-023 i_pause in WAIT_FRAME -> PAUSED; i_pause in SHIFT/WRITE: current sample completes and is written, then PAUSED instead of WAIT_FRAME.
REQ-024 PAUSED + i_start -> WAIT_FRAME, address and o_len retained.
REQ-025 i_stop in any state -> IDLE next edge; partial sample discarded, no o_wr; o_address, o_len hold.
REQ-026 Simultaneous pulses: stop > pause > start.
REQ-027 i_start while WAIT_FRAME/SHIFT/WRITE ignored; i_pause while IDLE/PAUSED ignored.
REQ-028 o_busy combinational from state; all other outputs registered.

Reset
REQ-029 While i_rst_n low: state IDLE, o_address 0, o_data 0, o_wr 0, o_len 0, o_full 0, bit counter 0, registered LRC 1.
REQ-030 Reset asserted mid-sample aborts without write; first deassert edge needs i_start before any capture.

Structure
REQ-031 State enum and SAMPLE_W=16, ADDR_W=20 reside in shared package aud_pkg for reuse by the player stage.
REQ-032 Single sub-module natural: aud_shift_in (16-bit MSB-first shift register with bit counter and done flag).
REQ-033 Estimated size 150-250 lines RTL.

Verification
REQ-034 start, one left frame data 16'hA5C3 -> o_wr at edge k+17, o_data 16'hA5C3, o_address 0; then o_address 1, o_len 1.
REQ-035 start, three frames 16'h0001,16'h8000,16'h7FFF -> writes at addresses 0,1,2 with those values; right-channel data 16'hFFFF never written.
REQ-036 i_stop at 8th bit of frame 2 -> no o_wr for that frame, state IDLE, o_len 1.
REQ-037 i_pause at 5th bit of frame 1 -> sample written at address 0, PAUSED, no writes for 3 frames; i_start -> next frame written to address 1.
REQ-038 ADDR_MAX=3, 6 frames -> writes at 0..3 only, o_full 1 after 4th write, o_busy 0; new i_start -> o_address 0, o_full 0.
REQ-039 i_stop+i_pause+i_start same cycle in SHIFT -> IDLE, no write; i_rst_n pulse mid-frame -> all outputs 0, no o_wr.
